// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: stage-register state encoding and default width.
package mips_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OCC_W  = 2;

   // Encoding doubles as the held-entry count (0..2).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

endpackage : mips_pkg

// File: rtl/pipe_skid_reg.sv
// Consumer-side pipeline register with a one-entry skid buffer.
// in_ready comes from a flop, so upstream never sees a combinational path from out_ready.
module pipe_skid_reg
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             in_fire, out_fire;

   // Handshake qualifiers use the registered ready/valid only.
   always_comb begin
      in_fire  = in_valid & in_ready_q;
      out_fire = out_valid_q & out_ready;
   end

   // Next-state and datapath selection; flush overrides every handshake.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = BUSY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      if (flush) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end

      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // State, data and handshake flops; reset clears all of them asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Outputs driven straight from flops.
   always_comb begin
      in_ready  = in_ready_q;
      out_valid = out_valid_q;
      out_data  = main_q;
      occupancy = OCC_W'(state_q);
   end

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized self-checking bench for pipe_skid_reg.
module tb_pipe_skid_reg;

   localparam int unsigned W = 32;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [1:0]    occupancy;

   int checks = 0;
   int errors = 0;

   pipe_skid_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic iv_r, input logic ov, input logic [1:0] occ,
                          input logic [W-1:0] dat, input logic chk_dat);
      chk({tag, ".in_ready"},  64'(in_ready),  64'(iv_r));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
      if (chk_dat) chk({tag, ".out_data"}, 64'(out_data), 64'(dat));
   endtask

   logic [W-1:0] q[$];
   logic         iv, ordy, fl;
   logic [W-1:0] d;
   logic         ifire, ofire;

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // 1. Reset, then pass-through at full rate.
      tick(); tick(); tick();
      chk_out("reset", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      rst = 1'b1;
      tick();
      chk_out("post_reset", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
      tick();
      chk_out("pass1", 1'b1, 1'b1, 2'd1, 32'h1, 1'b1);
      in_data = 32'h2;
      tick();
      chk_out("pass2", 1'b1, 1'b1, 2'd1, 32'h2, 1'b1);
      in_data = 32'h3;
      tick();
      chk_out("pass3", 1'b1, 1'b1, 2'd1, 32'h3, 1'b1);
      in_valid = 1'b0;
      tick();
      chk_out("drain", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

      // 2/3. Stall into FULL, extra push ignored, then drain in order.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
      tick();
      chk_out("stallA", 1'b1, 1'b1, 2'd1, 32'hA, 1'b1);
      in_data = 32'hB;
      tick();
      chk_out("full", 1'b0, 1'b1, 2'd2, 32'hA, 1'b1);
      in_data = 32'hDEAD;
      tick();
      chk_out("full_hold", 1'b0, 1'b1, 2'd2, 32'hA, 1'b1);
      out_ready = 1'b1;
      tick();
      chk_out("popA", 1'b1, 1'b1, 2'd1, 32'hB, 1'b1);
      in_valid = 1'b0;
      tick();
      chk_out("popB", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

      // 4. Flush in FULL with both handshakes active.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
      tick();
      in_data = 32'h22;
      tick();
      chk_out("pre_flush", 1'b0, 1'b1, 2'd2, 32'h11, 1'b1);
      flush = 1'b1; out_ready = 1'b1; in_data = 32'h55;
      tick();
      chk_out("flush", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      chk_out("post_flush", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

      // 5. Asynchronous reset between clock edges.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
      tick();
      chk_out("busy77", 1'b1, 1'b1, 2'd1, 32'h77, 1'b1);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      #1 rst = 1'b1;
      tick();
      chk_out("rst_release", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h88;
      tick();
      chk_out("resume", 1'b1, 1'b1, 2'd1, 32'h88, 1'b1);
      in_valid = 1'b0;
      tick();
      chk_out("resume_drain", 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);

      // 6. Random valid/ready/flush against a queue model.
      q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         iv   = ($urandom_range(0, 99) < 60);
         ordy = ($urandom_range(0, 99) < 55);
         fl   = ($urandom_range(0, 99) < 2);
         d    = W'($urandom());
         in_valid = iv; out_ready = ordy; flush = fl; in_data = d;
         ifire = iv && (q.size() < 2);
         ofire = ordy && (q.size() > 0);
         if (fl) begin
            q.delete();
         end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(d);
         end
         tick();
         chk_out("rand", (q.size() < 2), (q.size() > 0), 2'(q.size()),
                 (q.size() > 0) ? q[0] : '0, (q.size() > 0));
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pipe_skid_reg
